// File: rtl/led_pkg.sv
// ----------------------------------------------------------------------------
// led_pkg
// Shared definitions for the 16-LED pattern sequencer:
//   - mode_e : pattern encodings (ROT_L, ROT_R, BOUNCE, BLINK)
//   - dir_e  : bounce direction flag
//   - seed constants loaded on mode_load, plus a seed lookup helper
// ----------------------------------------------------------------------------
package led_pkg;

    localparam int unsigned LED_W = 16;

    typedef enum logic [1:0] {
        MODE_ROT_L  = 2'b00,
        MODE_ROT_R  = 2'b01,
        MODE_BOUNCE = 2'b10,
        MODE_BLINK  = 2'b11
    } mode_e;

    typedef enum logic {
        DIR_L = 1'b0,
        DIR_R = 1'b1
    } dir_e;

    localparam logic [LED_W-1:0] SEED_ROT_L  = 16'h0001;
    localparam logic [LED_W-1:0] SEED_ROT_R  = 16'h8000;
    localparam logic [LED_W-1:0] SEED_BOUNCE = 16'h0001;
    localparam logic [LED_W-1:0] SEED_BLINK  = 16'hFFFF;

    // Pattern value loaded when a mode is (re)started.
    function automatic logic [LED_W-1:0] seed_for(mode_e m);
        logic [LED_W-1:0] s;
        s = SEED_ROT_L;
        case (m)
            MODE_ROT_L:  s = SEED_ROT_L;
            MODE_ROT_R:  s = SEED_ROT_R;
            MODE_BOUNCE: s = SEED_BOUNCE;
            MODE_BLINK:  s = SEED_BLINK;
            default:     s = SEED_ROT_L;
        endcase
        return s;
    endfunction

endpackage

// File: rtl/led_step_gen.sv
// ----------------------------------------------------------------------------
// led_step_gen
// Step prescaler: counts clk cycles and emits a one-cycle step pulse every
// DIV*(speed_q+1) cycles. The speed input is captured only at a step or a
// restart so a mid-period speed change never shortens/lengthens the period
// already in progress.
// Ports:
//   i_clk     system clock
//   i_rst     synchronous active-high reset
//   i_restart restart pulse (mode_load): clears count, captures speed
//   i_pause   level: hold count, suppress step
//   i_speed   rate select
//   o_step    combinational step pulse (count at terminal, not paused/restarting)
// ----------------------------------------------------------------------------
module led_step_gen #(
    parameter int unsigned DIV   = 10,
    parameter int unsigned SPD_W = 4,
    parameter int unsigned CNT_W = 32
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_restart,
    input  logic             i_pause,
    input  logic [SPD_W-1:0] i_speed,
    output logic             o_step
);

    logic [CNT_W-1:0] r_cnt;
    logic [SPD_W-1:0] r_speed_q;
    logic [CNT_W-1:0] w_term;
    logic             w_at_term;

    assign w_term    = CNT_W'(DIV) * (CNT_W'(r_speed_q) + CNT_W'(1)) - CNT_W'(1);
    assign w_at_term = (r_cnt == w_term);
    assign o_step    = w_at_term && !i_pause && !i_restart;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_cnt     <= '0;
            r_speed_q <= '0;
        end else if (i_restart) begin
            r_cnt     <= '0;
            r_speed_q <= i_speed;
        end else if (i_pause) begin
            r_cnt     <= r_cnt;
            r_speed_q <= r_speed_q;
        end else if (o_step) begin
            r_cnt     <= '0;
            r_speed_q <= i_speed;
        end else begin
            r_cnt     <= r_cnt + CNT_W'(1);
        end
    end

endmodule

// File: rtl/led_pattern_ctrl.sv
// ----------------------------------------------------------------------------
// led_pattern_ctrl
// 16-LED pattern sequencer. Holds the active mode (FSM state, changes only on
// mode_load), the bounce direction flag and the LED register, and advances
// the pattern on every step from led_step_gen.
// Ports:
//   i_clk        system clock
//   i_rst        synchronous active-high reset
//   i_mode_sel   requested pattern (00 ROT_L, 01 ROT_R, 10 BOUNCE, 11 BLINK)
//   i_mode_load  one-cycle pulse: apply i_mode_sel and restart the pattern
//   i_speed      rate select, step period = DIV*(speed+1)
//   i_pause      level: freeze prescaler and LEDs
//   o_led        LED drive, active-high
//   o_step       one-cycle pulse on each pattern advance
//   o_cur_mode   currently active pattern
// ----------------------------------------------------------------------------
module led_pattern_ctrl
    import led_pkg::*;
#(
    parameter int unsigned DIV   = 10,
    parameter int unsigned SPD_W = 4,
    parameter int unsigned CNT_W = 32
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic [1:0]       i_mode_sel,
    input  logic             i_mode_load,
    input  logic [SPD_W-1:0] i_speed,
    input  logic             i_pause,
    output logic [15:0]      o_led,
    output logic             o_step,
    output logic [1:0]       o_cur_mode
);

    mode_e       r_mode;
    dir_e        r_dir;
    logic [15:0] r_led;

    mode_e       w_mode_d;
    dir_e        w_dir_d;
    logic [15:0] w_led_d;

    logic [15:0] w_led_adv;
    dir_e        w_dir_adv;
    dir_e        w_dir_eff;
    logic        w_step;

    led_step_gen #(
        .DIV   (DIV),
        .SPD_W (SPD_W),
        .CNT_W (CNT_W)
    ) u_step_gen (
        .i_clk     (i_clk),
        .i_rst     (i_rst),
        .i_restart (i_mode_load),
        .i_pause   (i_pause),
        .i_speed   (i_speed),
        .o_step    (w_step)
    );

    // Per-mode next pattern value, used only when a step fires.
    always_comb begin
        w_led_adv = r_led;
        w_dir_adv = r_dir;
        w_dir_eff = r_dir;
        unique case (r_mode)
            MODE_ROT_L:  w_led_adv = {r_led[14:0], r_led[15]};
            MODE_ROT_R:  w_led_adv = {r_led[0], r_led[15:1]};
            MODE_BOUNCE: begin
                // An end bit forces the move away from that end, so the
                // pattern can never shift the hot bit out of the register.
                if (r_led[15]) begin
                    w_dir_eff = DIR_R;
                end else if (r_led[0]) begin
                    w_dir_eff = DIR_L;
                end
                w_led_adv = (w_dir_eff == DIR_L) ? (r_led << 1) : (r_led >> 1);
                // Flip on the step that lands on an end: 4000->8000->4000.
                if (w_led_adv[15]) begin
                    w_dir_adv = DIR_R;
                end else if (w_led_adv[0]) begin
                    w_dir_adv = DIR_L;
                end else begin
                    w_dir_adv = w_dir_eff;
                end
            end
            MODE_BLINK:  w_led_adv = ~r_led;
        endcase
        // Hot-bit modes recover to their seed if the register was ever empty.
        if (r_mode != MODE_BLINK && r_led == '0) begin
            w_led_adv = seed_for(r_mode);
            w_dir_adv = DIR_L;
        end
    end

    // Next-state: mode_load beats step; pause is already folded into w_step.
    always_comb begin
        w_mode_d = r_mode;
        w_dir_d  = r_dir;
        w_led_d  = r_led;
        if (i_mode_load) begin
            w_mode_d = mode_e'(i_mode_sel);
            w_led_d  = seed_for(mode_e'(i_mode_sel));
            w_dir_d  = DIR_L;
        end else if (w_step) begin
            w_led_d = w_led_adv;
            w_dir_d = w_dir_adv;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_mode <= MODE_ROT_L;
            r_dir  <= DIR_L;
            r_led  <= SEED_ROT_L;
        end else begin
            r_mode <= w_mode_d;
            r_dir  <= w_dir_d;
            r_led  <= w_led_d;
        end
    end

    assign o_led      = r_led;
    assign o_step     = w_step;
    assign o_cur_mode = r_mode;

endmodule
